joy_serializer: RTL

Emulates the two-port 16-bit parallel-in/serial-out joystick shift-register chain as seen from the FPGA's joystick pins. It captures MEGA65 native DB9 joystick lines and answers an external `joy_clk`/`joy_load_n` master, such as the team's `joydecoder`, with a serial `joy_data` stream. It sits beside the top level and is used both as a bridge to boards without the serial joystick adapter and as the responder model in joystick-path benches. All logic runs on the 28 MHz system clock; the master's strobes are treated as asynchronous inputs.

---
 rtl/joy_serializer.sv | 103 ++++++++++
 1 files changed

// File: rtl/joy_serializer.sv
// Serial joystick responder: captures two DB9 ports and replays them as a 16-bit
// frame to an external joy_clk/joy_load_n master. All logic runs on the system clock.
module joy_serializer #(
  parameter int DEBOUNCE = 28000,
  parameter int DBW      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] joy1_n,
  input  logic [7:0] joy2_n,
  input  logic       joy_clk,
  input  logic       joy_load_n,
  output logic       joy_data,
  output logic       frame_done
);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

  logic [15:0]    btn_m;
  logic [15:0]    btn_s;
  logic [1:0]     clk_sync;
  logic [1:0]     load_sync;
  logic           clk_s;
  logic           load_s;
  logic           clk_p;
  logic [15:0]    acc;
  logic [DBW-1:0] cnt [16];
  logic [15:0]    load_word;
  logic [15:0]    sr;
  logic [4:0]     bitcnt;

  assign clk_s  = clk_sync[1];
  assign load_s = load_sync[1];

  // Button lines are held as {joy2_n, joy1_n}; released levels are 1.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) begin
      btn_m     <= '1;
      btn_s     <= '1;
      clk_sync  <= '0;
      load_sync <= '1;
      clk_p     <= 1'b0;
    end else begin
      btn_m     <= {joy2_n, joy1_n};
      btn_s     <= btn_m;
      clk_sync  <= {clk_sync[0], joy_clk};
      load_sync <= {load_sync[0], joy_load_n};
      clk_p     <= clk_s;
    end
  end

  // A line is accepted only after DEBOUNCE consecutive cycles away from acc.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '1;
      // NOTE: cnt is a small register array, not a RAM, so resetting it is cheap and keeps acceptance deterministic.
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (DEBOUNCE == 0) begin
          acc[i] <= btn_s[i];
          cnt[i] <= '0;
        end else if (btn_s[i] == acc[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          acc[i] <= btn_s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // j1 up lands in sr[15] and j2 start in sr[0]: the frame is acc bit-reversed.
  always_comb begin
    // NOTE: default first so no path leaves load_word unassigned and infers a latch.
    load_word = '1;
    for (int i = 0; i < 16; i++) load_word[15-i] = acc[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= '1;
      bitcnt     <= 5'd16;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!load_s) begin
        sr     <= load_word;
        bitcnt <= '0;
      end else if (clk_s && !clk_p) begin
        sr <= {sr[14:0], 1'b1};
        if (bitcnt != 5'd16) bitcnt <= bitcnt + 1'b1;
        if (bitcnt == 5'd15) frame_done <= 1'b1;
      end
    end
  end

  assign joy_data = sr[15];

endmodule
